// File: rtl/srff_pkg.sv
// Shared types and SR next-state function
// for the SR flip-flop checker.
package srff_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        CHECK   = 2'd2,
        UNKNOWN = 2'd3
    } state_e;

    // s=r=1 has no defined result; holding is as good as any guess
    // because the checker never compares after an illegal sample.
    function automatic logic sr_next(
        input logic q,
        input logic s,
        input logic r
    );
        logic nq;
        case ({s, r})
            2'b01:   nq = 1'b0;
            2'b10:   nq = 1'b1;
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/srff_model.sv
// Reference model of the observed flop:
// holds the expected q for the next compare.
module srff_model
    import srff_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic upd,
    input  logic q,
    input  logic s,
    input  logic r,
    output logic exp_q
);

    logic exp_d;

    // SYNC seeds from the live q, CHECK advances the model itself
    always_comb begin
        exp_d = exp_q;
        if (load) begin
            exp_d = sr_next(q, s, r);
        end else if (upd) begin
            exp_d = sr_next(exp_q, s, r);
        end
    end

    // Expected-value register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
        end
    end

endmodule

// File: rtl/srff_checker.sv
// Observes an SR flip-flop and flags output
// mismatches, illegal s=r=1 and keeps counters.
module srff_checker
    import srff_pkg::*;
#(
    parameter int ERR_W = 8,
    parameter int CHK_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             qb,
    output logic             mismatch,
    output logic             illegal,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CHK_W-1:0] chk_cnt,
    output logic [1:0]       state
);

    state_e           state_q, state_d;
    logic             mis_q, mis_d;
    logic             ill_q, ill_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [CHK_W-1:0] chk_cnt_q, chk_cnt_d;
    logic             exp_q;
    logic             active;
    logic             in_chk;
    logic             in_sync;

    // With en low nothing is checked, so a return to IDLE
    // never carries a stale pulse into the IDLE cycle.
    assign in_sync = en && (state_q == SYNC);
    assign in_chk  = en && (state_q == CHECK);
    assign active  = in_sync || in_chk;

    srff_model u_model (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (in_sync),
        .upd   (in_chk),
        .q     (q),
        .s     (s),
        .r     (r),
        .exp_q (exp_q)
    );

    // Next state, check results and saturating counters
    always_comb begin
        state_d   = state_q;
        mis_d     = 1'b0;
        ill_d     = 1'b0;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        chk_cnt_d = chk_cnt_q;

        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = SYNC;
                SYNC:    state_d = (s && r) ? UNKNOWN : CHECK;
                CHECK:   state_d = (s && r) ? UNKNOWN : CHECK;
                UNKNOWN: state_d = SYNC;
                default: state_d = IDLE;
            endcase
        end

        if (active) begin
            ill_d = s && r;
            mis_d = (qb == q) || (in_chk && (q != exp_q));
        end

        if (in_chk && (chk_cnt_q != '1)) begin
            chk_cnt_d = chk_cnt_q + CHK_W'(1);
        end

        if (mis_d) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end
    end

    // State, pulse and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mis_q     <= 1'b0;
            ill_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            chk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mis_q     <= mis_d;
            ill_q     <= ill_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            chk_cnt_q <= chk_cnt_d;
        end
    end

    assign mismatch = mis_q;
    assign illegal  = ill_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign chk_cnt  = chk_cnt_q;
    assign state    = state_q;

endmodule

// File: tb/tb_srff_checker.sv
// Scoreboard bench for srff_checker: directed cycles
// push expected outputs, a monitor pops and compares.
module tb_srff_checker;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        s;
    logic        r;
    logic        q;
    logic        qb;
    logic        mismatch;
    logic        illegal;
    logic        err;
    logic [7:0]  err_cnt;
    logic [15:0] chk_cnt;
    logic [1:0]  state;
    logic        mismatch2;
    logic        illegal2;
    logic        err2;
    logic [1:0]  err_cnt2;
    logic [15:0] chk_cnt2;
    logic [1:0]  state2;

    int checks;
    int failures;

    typedef struct {
        logic [1:0]  st;
        logic        mis;
        logic        ill;
        logic        er;
        logic [7:0]  ecnt;
        logic [1:0]  ecnt2;
        logic [15:0] ccnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_t;

    srff_checker #(.ERR_W(8), .CHK_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .s        (s),
        .r        (r),
        .q        (q),
        .qb       (qb),
        .mismatch (mismatch),
        .illegal  (illegal),
        .err      (err),
        .err_cnt  (err_cnt),
        .chk_cnt  (chk_cnt),
        .state    (state)
    );

    srff_checker #(.ERR_W(2), .CHK_W(16)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .s        (s),
        .r        (r),
        .q        (q),
        .qb       (qb),
        .mismatch (mismatch2),
        .illegal  (illegal2),
        .err      (err2),
        .err_cnt  (err_cnt2),
        .chk_cnt  (chk_cnt2),
        .state    (state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // One cycle: drive inputs before the edge, queue what must follow it
    task automatic cyc(
        input logic rn, input logic e,
        input logic sv, input logic rv,
        input logic qv, input logic qbv,
        input int st, input logic mis, input logic ill,
        input logic er, input int ec, input int cc
    );
        exp_t t;
        @(negedge clk);
        rst_n = rn;
        en    = e;
        s     = sv;
        r     = rv;
        q     = qv;
        qb    = qbv;
        t.st    = 2'(st);
        t.mis   = mis;
        t.ill   = ill;
        t.er    = er;
        t.ecnt  = 8'(ec);
        t.ecnt2 = (ec > 3) ? 2'd3 : 2'(ec);
        t.ccnt  = 16'(cc);
        sb.push_back(t);
    endtask

    // Monitor: outputs settle just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_t = sb.pop_front();
                chk("state", int'(state), int'(mon_t.st));
                chk("mismatch", int'(mismatch), int'(mon_t.mis));
                chk("illegal", int'(illegal), int'(mon_t.ill));
                chk("err", int'(err), int'(mon_t.er));
                chk("err_cnt", int'(err_cnt), int'(mon_t.ecnt));
                chk("err_cnt_w2", int'(err_cnt2), int'(mon_t.ecnt2));
                chk("chk_cnt", int'(chk_cnt), int'(mon_t.ccnt));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        s     = 1'b0;
        r     = 1'b0;
        q     = 1'b0;
        qb    = 1'b1;

        // reset state
        cyc(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        // clean flop, s/r = 00,01,10,00
        cyc(1, 1, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1,  2, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 0, 1,  2, 0, 0, 0, 0, 1);
        cyc(1, 1, 1, 0, 0, 1,  2, 0, 0, 0, 0, 2);
        cyc(1, 1, 0, 0, 1, 0,  2, 0, 0, 0, 0, 3);
        // set, then q forced low
        cyc(1, 1, 1, 0, 1, 0,  2, 0, 0, 0, 0, 4);
        cyc(1, 1, 0, 0, 0, 1,  2, 1, 0, 1, 1, 5);
        cyc(1, 1, 0, 0, 1, 0,  2, 0, 0, 1, 1, 6);
        // qb equal to q
        cyc(1, 1, 0, 0, 1, 1,  2, 1, 0, 1, 2, 7);
        cyc(1, 1, 0, 0, 1, 0,  2, 0, 0, 1, 2, 8);
        // s=r=1: UNKNOWN, then resync; stale q not flagged
        cyc(1, 1, 1, 1, 1, 0,  3, 0, 1, 1, 2, 9);
        cyc(1, 1, 0, 0, 0, 1,  1, 0, 0, 1, 2, 9);
        cyc(1, 1, 0, 0, 0, 1,  2, 0, 0, 1, 2, 9);
        cyc(1, 1, 0, 1, 0, 1,  2, 0, 0, 1, 2, 10);
        // five back-to-back mismatches, narrow counter saturates
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0, 0, 0, 0,  2, 1, 0, 1, 3 + i, 11 + i);
        end
        cyc(1, 1, 0, 0, 0, 1,  2, 0, 0, 1, 7, 16);
        // en low: back to IDLE, counters hold
        cyc(1, 0, 0, 0, 0, 1,  0, 0, 0, 1, 7, 16);
        cyc(1, 0, 0, 0, 0, 1,  0, 0, 0, 1, 7, 16);
        cyc(1, 1, 0, 0, 0, 1,  1, 0, 0, 1, 7, 16);
        cyc(1, 1, 0, 0, 0, 1,  2, 0, 0, 1, 7, 16);
        cyc(1, 1, 0, 0, 0, 1,  2, 0, 0, 1, 7, 17);
        // reset mid-check, release with en high
        cyc(0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1,  2, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1,  2, 0, 0, 0, 0, 1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
